// File: rtl/sysarray_sequencer.sv
// Job sequencer for the systolic array: walks each tile of a job through
// accumulator flush, operand load, a fixed compute window and result capture,
// then hands the job's prune decision over from the mean unit.
module sysarray_sequencer #(
    parameter int COMPUTE_CYCLES = 12,
    parameter int TILE_BITS      = 4
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 start,
    output logic                 start_ready,
    input  logic                 add_en,
    input  logic                 int_en,
    input  logic [TILE_BITS-1:0] num_tiles,
    input  logic                 head_prune,
    output logic                 _flush_acc,
    output logic                 op_load,
    output logic                 AddFlag,
    output logic                 IntFlag,
    output logic                 done,
    output logic                 endofINT_INT_Mat,
    output logic                 capture,
    output logic [TILE_BITS-1:0] tile_idx,
    output logic                 busy,
    output logic                 job_done,
    output logic                 prune_flag
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        LOAD    = 3'd2,
        COMPUTE = 3'd3,
        CAPTURE = 3'd4,
        MEAN    = 3'd5
    } state_t;

    // The compute counter is loaded with COMPUTE_CYCLES-1 so that COMPUTE
    // occupies exactly COMPUTE_CYCLES cycles, leaving on the cycle it reads 0.
    localparam logic [7:0] CNT_LOAD = 8'(COMPUTE_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           cnt;
    logic [TILE_BITS-1:0] tile_q;
    logic [TILE_BITS-1:0] last_q;
    logic                 add_q;
    logic                 int_q;
    logic                 prune_q;
    logic                 accept;
    logic                 last_tile;

    assign accept    = (state == IDLE) && start;
    assign last_tile = (tile_q == last_q);

    // State register; reset wins over any concurrent start.
    always_ff @(posedge clk) begin
        if (_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: every state other than COMPUTE lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FLUSH;
            FLUSH:   state_nxt = LOAD;
            LOAD:    state_nxt = COMPUTE;
            COMPUTE: if (cnt == 8'd0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = last_tile ? MEAN : FLUSH;
            MEAN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job context: options latched at acceptance so later input changes
    // cannot disturb a running job; tile index and compute countdown.
    always_ff @(posedge clk) begin
        if (_reset) begin
            cnt    <= 8'd0;
            tile_q <= '0;
            last_q <= '0;
            add_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            if (accept) begin
                tile_q <= '0;
                // A request for zero tiles runs as a single tile.
                last_q <= (num_tiles == '0) ? '0 : num_tiles - 1'b1;
                add_q  <= add_en;
                int_q  <= add_en && int_en;
            end else if (state == CAPTURE && !last_tile) begin
                tile_q <= tile_q + 1'b1;
            end else if (state == MEAN) begin
                tile_q <= '0;
            end

            if (state == LOAD) begin
                cnt <= CNT_LOAD;
            end else if (state == COMPUTE && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Prune decision is taken from the mean unit only when a job completes.
    always_ff @(posedge clk) begin
        if (_reset) begin
            prune_q <= 1'b0;
        end else if (state == MEAN) begin
            prune_q <= head_prune;
        end
    end

    // Output decode from state plus latched job context only.
    always_comb begin
        start_ready      = (state == IDLE);
        busy             = (state != IDLE);
        _flush_acc       = (state != FLUSH);
        op_load          = (state == LOAD);
        done             = (state == CAPTURE);
        capture          = (state == CAPTURE);
        endofINT_INT_Mat = (state == CAPTURE) && last_tile;
        job_done         = (state == MEAN);
        AddFlag          = 1'b0;
        IntFlag          = 1'b0;
        if (state == FLUSH || state == LOAD || state == COMPUTE || state == CAPTURE) begin
            AddFlag = add_q;
            IntFlag = int_q;
        end
        tile_idx         = tile_q;
        prune_flag       = prune_q;
    end

endmodule
